// File: rtl/i2c_reg_ctrl_if.sv
// Byte-level bus between the register controller and the I2C bit-shift stage.
interface i2c_reg_ctrl_if;
  logic [5:0] Cmd;
  logic       Go;
  logic [7:0] Tx_DATA;
  logic [7:0] Rx_DATA;
  logic       Trans_Done;
  logic       ack_o;

  modport master (output Cmd, Go, Tx_DATA, input Rx_DATA, Trans_Done, ack_o);
  modport slave  (input Cmd, Go, Tx_DATA, output Rx_DATA, Trans_Done, ack_o);
endinterface

// File: rtl/i2c_reg_ctrl.sv
// I2C register read/write sequencer: turns one request into a series of byte commands.
// Optional I2C_RETRY_EN: a transaction that saw a NACK is replayed, up to 3 attempts.
module i2c_reg_ctrl (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        wrreg_req,
  input  logic        rdreg_req,
  input  logic [7:0]  device_id,
  input  logic [15:0] addr,
  input  logic        addr_mode,
  input  logic [7:0]  wrdata,
  output logic [7:0]  rddata,
  output logic        RW_Done,
  output logic        ack,
  i2c_reg_ctrl_if.master bus
);
  localparam logic [5:0] CMD_WR   = 6'b000001;
  localparam logic [5:0] CMD_STA  = 6'b000010;
  localparam logic [5:0] CMD_RD   = 6'b000100;
  localparam logic [5:0] CMD_STO  = 6'b001000;
  localparam logic [5:0] CMD_NACK = 6'b100000;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [2:0]  cnt;
  logic [2:0]  step;
  logic [6:0]  id_q;
  logic [15:0] addr_q;
  logic        mode_q;
  logic [7:0]  data_q;
  logic        is_rd;
  logic        err;
  logic        err_nxt;
  logic        last_byte;
  logic        retry;
  logic        req;
  logic [5:0]  cur_cmd;
  logic [7:0]  cur_tx;

  assign req = wrreg_req | rdreg_req;

  // 8-bit addressing skips the high-address slot of the logical sequence
  always_comb begin
    step = cnt;
    if (!mode_q && cnt != 3'd0) step = cnt + 3'd1;
  end

  always_comb begin
    cur_cmd = CMD_RD | CMD_NACK | CMD_STO;
    cur_tx  = 8'h00;
    case (step)
      3'd0: begin cur_cmd = CMD_STA | CMD_WR; cur_tx = {id_q, 1'b0}; end
      3'd1: begin cur_cmd = CMD_WR;           cur_tx = addr_q[15:8]; end
      3'd2: begin cur_cmd = CMD_WR;           cur_tx = addr_q[7:0];  end
      3'd3: begin
        if (is_rd) begin cur_cmd = CMD_STA | CMD_WR; cur_tx = {id_q, 1'b1}; end
        else       begin cur_cmd = CMD_WR | CMD_STO; cur_tx = data_q;       end
      end
      default: ;
    endcase
  end

  assign last_byte = is_rd ? (step == 3'd4) : (step == 3'd3);
  // the RD byte's ack_o is our own NACK, not a slave error
  assign err_nxt   = err | (bus.Cmd[0] & bus.ack_o);

`ifdef I2C_RETRY_EN
  logic [1:0] retry_cnt;
  assign retry = err_nxt && (retry_cnt != 2'd2);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      retry_cnt <= 2'd0;
    end else if (state == S_IDLE && req) begin
      retry_cnt <= 2'd0;
    end else if (state == S_WAIT && bus.Trans_Done && last_byte && retry) begin
      retry_cnt <= retry_cnt + 2'd1;
    end
  end
`else
  assign retry = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (bus.Trans_Done) begin
          if (!last_byte || retry) state_nxt = S_ISSUE;
          else                     state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt         <= 3'd0;
      id_q        <= 7'd0;
      addr_q      <= 16'd0;
      mode_q      <= 1'b0;
      data_q      <= 8'd0;
      is_rd       <= 1'b0;
      err         <= 1'b0;
      bus.Cmd     <= 6'd0;
      bus.Go      <= 1'b0;
      bus.Tx_DATA <= 8'd0;
      rddata      <= 8'd0;
      RW_Done     <= 1'b0;
      ack         <= 1'b0;
    end else begin
      bus.Go  <= 1'b0;
      RW_Done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            is_rd  <= ~wrreg_req;
            id_q   <= device_id[7:1];
            addr_q <= addr;
            mode_q <= addr_mode;
            data_q <= wrdata;
            err    <= 1'b0;
            ack    <= 1'b0;
            cnt    <= 3'd0;
          end
        end
        S_ISSUE: begin
          bus.Cmd     <= cur_cmd;
          bus.Tx_DATA <= cur_tx;
          bus.Go      <= 1'b1;
        end
        S_WAIT: begin
          if (bus.Trans_Done) begin
            if ((bus.Cmd & CMD_RD) != 6'd0) rddata <= bus.Rx_DATA;
            if (!last_byte) begin
              cnt <= cnt + 3'd1;
              err <= err_nxt;
            end else if (retry) begin
              cnt <= 3'd0;
              err <= 1'b0;
            end else begin
              err     <= err_nxt;
              ack     <= err_nxt;
              RW_Done <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Directed vector bench for i2c_reg_ctrl with a cycle-stepped byte-stage slave model.
module tb_i2c_reg_ctrl;
  logic        Clk, Rst_n;
  logic        wrreg_req, rdreg_req, addr_mode;
  logic [7:0]  device_id, wrdata, rddata;
  logic [15:0] addr;
  logic        RW_Done, ack;

  i2c_reg_ctrl_if bus();

  i2c_reg_ctrl dut (
    .Clk(Clk), .Rst_n(Rst_n), .wrreg_req(wrreg_req), .rdreg_req(rdreg_req),
    .device_id(device_id), .addr(addr), .addr_mode(addr_mode), .wrdata(wrdata),
    .rddata(rddata), .RW_Done(RW_Done), .ack(ack), .bus(bus)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  typedef struct {
    bit              wr, rd, mode;
    logic [7:0]      id;
    logic [15:0]     a;
    logic [7:0]      d;
    logic [15:0]     nack;
    logic [7:0]      rx;
    bit              inj;
    int              n;
    logic [4:0][5:0] cmd;
    logic [4:0][7:0] tx;
    logic            exp_ack;
    logic [7:0]      rdd;
  } vec_t;

  vec_t vt[6];
  int   checks = 0, passes = 0;

  int         go_n, done_n, first_go, done_lat, stable_bad;
  logic [5:0] cmd_log[16];
  logic [7:0] tx_log[16];

  function automatic logic [4:0][5:0] c5(input logic [5:0] a, b, c, d, e);
    c5[0] = a; c5[1] = b; c5[2] = c; c5[3] = d; c5[4] = e;
  endfunction

  function automatic logic [4:0][7:0] t5(input logic [7:0] a, b, c, d, e);
    t5[0] = a; t5[1] = b; t5[2] = c; t5[3] = d; t5[4] = e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Steps one clock at a time, acting as the bit-shift stage: Trans_Done 3 cycles after Go.
  task automatic service(input logic [15:0] nack, input logic [7:0] rx, input bit inj,
                         input int abort_go, input int max_cyc);
    int   cd, last_td, quiet;
    logic pend;
    cd = 0; last_td = 0; quiet = 0; pend = 1'b0;
    go_n = 0; done_n = 0; first_go = 0; done_lat = -1; stable_bad = 0;
    for (int i = 1; i <= max_cyc; i++) begin
      @(posedge Clk); #1;
      wrreg_req = 1'b0; rdreg_req = 1'b0;
      bus.Trans_Done = 1'b0; bus.ack_o = 1'b0;
      if (RW_Done) begin
        done_n++;
        if (done_n == 1) done_lat = i - last_td;
      end
      if (bus.Go) begin
        if (go_n < 16) begin
          cmd_log[go_n] = bus.Cmd;
          tx_log[go_n]  = bus.Tx_DATA;
          pend = nack[go_n];
        end
        if (go_n == 0) first_go = i;
        go_n++;
        cd = 3;
      end else if (cd > 0) begin
        if (go_n <= 16 && (bus.Cmd !== cmd_log[go_n-1] || bus.Tx_DATA !== tx_log[go_n-1]))
          stable_bad++;
        cd--;
        if (cd == 0) begin
          bus.Trans_Done = 1'b1;
          bus.ack_o      = pend;
          bus.Rx_DATA    = rx;
          last_td        = i;
        end
      end
      if (inj && go_n == 1 && cd == 2) rdreg_req = 1'b1;
      if (abort_go != 0 && go_n == abort_go && cd == 2) begin
        Rst_n = 1'b0;
        break;
      end
      if (done_n > 0) begin
        quiet++;
        if (quiet > 4) break;
      end
    end
  endtask

  task automatic start(input vec_t v);
    @(posedge Clk); #1;
    wrreg_req = v.wr; rdreg_req = v.rd; addr_mode = v.mode;
    device_id = v.id; addr = v.a; wrdata = v.d;
  endtask

  initial begin
    vec_t v;
    int   lim;
    Rst_n = 1'b0; wrreg_req = 1'b0; rdreg_req = 1'b0; addr_mode = 1'b0;
    device_id = 8'h00; addr = 16'h0000; wrdata = 8'h00;
    bus.Rx_DATA = 8'h00; bus.Trans_Done = 1'b0; bus.ack_o = 1'b0;

    vt[0] = '{1'b1, 1'b0, 1'b0, 8'h78, 16'h0030, 8'h5A, 16'h0000, 8'h00, 1'b0, 3,
              c5(6'h03, 6'h01, 6'h09, 6'h00, 6'h00), t5(8'h78, 8'h30, 8'h5A, 8'h00, 8'h00),
              1'b0, 8'h00};
    vt[1] = '{1'b0, 1'b1, 1'b1, 8'h78, 16'h3008, 8'h00, 16'h0000, 8'hC3, 1'b0, 5,
              c5(6'h03, 6'h01, 6'h01, 6'h03, 6'h2C), t5(8'h78, 8'h30, 8'h08, 8'h79, 8'h00),
              1'b0, 8'hC3};
`ifdef I2C_RETRY_EN
    vt[2] = '{1'b1, 1'b0, 1'b0, 8'h78, 16'h0030, 8'h5A, 16'h0092, 8'h00, 1'b0, 9,
              c5(6'h03, 6'h01, 6'h09, 6'h03, 6'h01), t5(8'h78, 8'h30, 8'h5A, 8'h78, 8'h30),
              1'b1, 8'hC3};
    vt[3] = '{1'b1, 1'b0, 1'b0, 8'h78, 16'h0030, 8'h5A, 16'h0002, 8'h00, 1'b0, 6,
              c5(6'h03, 6'h01, 6'h09, 6'h03, 6'h01), t5(8'h78, 8'h30, 8'h5A, 8'h78, 8'h30),
              1'b0, 8'hC3};
`else
    vt[2] = '{1'b1, 1'b0, 1'b0, 8'h78, 16'h0030, 8'h5A, 16'h0002, 8'h00, 1'b0, 3,
              c5(6'h03, 6'h01, 6'h09, 6'h00, 6'h00), t5(8'h78, 8'h30, 8'h5A, 8'h00, 8'h00),
              1'b1, 8'hC3};
    vt[3] = '{1'b1, 1'b0, 1'b1, 8'hA1, 16'h1234, 8'h77, 16'h0000, 8'h00, 1'b0, 4,
              c5(6'h03, 6'h01, 6'h01, 6'h09, 6'h00), t5(8'hA0, 8'h12, 8'h34, 8'h77, 8'h00),
              1'b0, 8'hC3};
`endif
    // both requests together: write wins
    vt[4] = '{1'b1, 1'b1, 1'b0, 8'h50, 16'h0011, 8'hEE, 16'h0000, 8'h00, 1'b0, 3,
              c5(6'h03, 6'h01, 6'h09, 6'h00, 6'h00), t5(8'h50, 8'h11, 8'hEE, 8'h00, 8'h00),
              1'b0, 8'hC3};
    // 8-bit read, NACK on RD byte must not flag an error, stray rdreg_req in WAIT
    vt[5] = '{1'b0, 1'b1, 1'b0, 8'h79, 16'h00FF, 8'h00, 16'h0008, 8'h3C, 1'b1, 4,
              c5(6'h03, 6'h01, 6'h03, 6'h2C, 6'h00), t5(8'h78, 8'hFF, 8'h79, 8'h00, 8'h00),
              1'b0, 8'h3C};

    repeat (3) @(posedge Clk);
    #1;
    chk("reset_cmd", 32'(bus.Cmd), 32'h0);
    chk("reset_go", 32'(bus.Go), 32'h0);
    chk("reset_tx", 32'(bus.Tx_DATA), 32'h0);
    chk("reset_rddata", 32'(rddata), 32'h0);
    chk("reset_rwdone", 32'(RW_Done), 32'h0);
    chk("reset_ack", 32'(ack), 32'h0);
    Rst_n = 1'b1;

    for (int k = 0; k < 6; k++) begin
      v = vt[k];
      start(v);
      service(v.nack, v.rx, v.inj, 0, 300);
      chk($sformatf("v%0d_go_count", k), 32'(go_n), 32'(v.n));
      chk($sformatf("v%0d_go_latency", k), 32'(first_go), 32'd2);
      lim = (v.n < 5) ? v.n : 5;
      for (int b = 0; b < lim; b++) begin
        chk($sformatf("v%0d_cmd%0d", k, b), 32'(cmd_log[b]), 32'(v.cmd[b]));
        if (v.cmd[b] != 6'h2C)
          chk($sformatf("v%0d_tx%0d", k, b), 32'(tx_log[b]), 32'(v.tx[b]));
      end
      chk($sformatf("v%0d_rwdone_count", k), 32'(done_n), 32'd1);
      chk($sformatf("v%0d_done_latency", k), 32'(done_lat), 32'd1);
      chk($sformatf("v%0d_stable", k), 32'(stable_bad), 32'd0);
      chk($sformatf("v%0d_ack", k), 32'(ack), 32'(v.exp_ack));
      chk($sformatf("v%0d_rddata", k), 32'(rddata), 32'(v.rdd));
      repeat (2) @(posedge Clk);
    end

    // reset while waiting on byte 2
    v = vt[0];
    start(v);
    service(v.nack, v.rx, 1'b0, 2, 300);
    chk("abort_reached_byte2", 32'(go_n), 32'd2);
    #1;
    chk("abort_cmd", 32'(bus.Cmd), 32'h0);
    chk("abort_tx", 32'(bus.Tx_DATA), 32'h0);
    chk("abort_go", 32'(bus.Go), 32'h0);
    chk("abort_rddata", 32'(rddata), 32'h0);
    chk("abort_ack", 32'(ack), 32'h0);
    repeat (2) @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    bus.Trans_Done = 1'b0;
    service(16'h0000, 8'h00, 1'b0, 0, 12);
    chk("abort_no_rwdone", 32'(done_n), 32'd0);
    chk("abort_no_go", 32'(go_n), 32'd0);

    start(v);
    service(v.nack, v.rx, 1'b0, 0, 300);
    chk("post_abort_go_count", 32'(go_n), 32'd3);
    chk("post_abort_cmd0", 32'(cmd_log[0]), 32'h03);
    chk("post_abort_cmd2", 32'(cmd_log[2]), 32'h09);
    chk("post_abort_tx2", 32'(tx_log[2]), 32'h5A);
    chk("post_abort_rwdone", 32'(done_n), 32'd1);
    chk("post_abort_ack", 32'(ack), 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/i2c_reg_ctrl.md
I2C_REG_CTRL -- requirements
Module: i2c_reg_ctrl

Interface
REQ-001 Parameter: none; the command codes are fixed: WR=6'b000001, STA=6'b000010, RD=6'b000100, STO=6'b001000, ACK=6'b010000, NACK=6'b100000.
REQ-002 Clk  input  1  system clock; one clock, reset is asynchronous and active-low.
REQ-003 Rst_n  input  1  asynchronous active-low reset.
REQ-004 wrreg_req  input  1  one-cycle request for a register write.
REQ-005 rdreg_req  input  1  one-cycle request for a register read.
REQ-006 device_id  input  8  7-bit slave address in [7:1]; bit 0 ignored.
REQ-007 addr  input  16  register address.
REQ-008 addr_mode  input  1  1 = 16-bit address (2 bytes), 0 = 8-bit address (addr[7:0] only).
REQ-009 wrdata  input  8  write data.
REQ-010 rddata  output  8  last read data.
REQ-011 RW_Done  output  1  one-cycle pulse when the transaction ends.
REQ-012 ack  output  1  1 = at least one write byte was NACKed in the last transaction.
REQ-013 Cmd  output  6  byte command to the bit-shift stage.
REQ-014 Go  output  1  one-cycle byte start strobe.
REQ-015 Tx_DATA  output  8  byte to transmit.
REQ-016 Rx_DATA  input  8  received byte.
REQ-017 Trans_Done  input  1  byte-complete pulse.
REQ-018 ack_o  input  1  sampled slave ACK bit (1 = NACK).

Function
REQ-019 States: IDLE, ISSUE, WAIT, DONE; a byte counter selects the current byte.
REQ-020 In IDLE, wrreg_req or rdreg_req latches device_id, addr, addr_mode and wrdata, clears the error flag and enters ISSUE.
REQ-021 If both requests are asserted in the same IDLE cycle, the write wins; requests outside IDLE are ignored.
REQ-022 Write sequence: {STA|WR, id&8'hFE}; {WR, addr[15:8]} only if addr_mode=1; {WR|STO, wrdata}, where addr_mode=1 inserts {WR, addr[7:0]} before the data byte and addr_mode=0 uses {WR, addr[7:0]} in that position.
REQ-023 Read sequence: {STA|WR, id&8'hFE}; {WR, addr[15:8]} only if addr_mode=1; {WR, addr[7:0]}; {STA|WR, id|8'h01}; {RD|NACK|STO, don't-care}.
REQ-024 ISSUE drives Cmd/Tx_DATA for the current byte, asserts Go for exactly one cycle, then enters WAIT.
REQ-025 Cmd and Tx_DATA stay stable from ISSUE until Trans_Done is sampled.
REQ-026 In WAIT, on Trans_Done: for a write-type byte, OR ack_o into the error flag; if more bytes remain, advance the counter and enter ISSUE; otherwise enter DONE.
REQ-027 On the Trans_Done of the RD byte, rddata <= Rx_DATA; ack_o is not accumulated for the RD byte.
REQ-028 DONE pulses RW_Done for one cycle, drives ack = error flag (held until the next request is accepted) and returns to IDLE.
REQ-029 Latency from a request to the first Go is 2 cycles; from the final Trans_Done to RW_Done is 1 cycle.
REQ-030 Go is never asserted in WAIT, DONE or IDLE.

Reset
REQ-031 On Rst_n low, asynchronously: state=IDLE, counter=0, Cmd=0, Go=0, Tx_DATA=0, rddata=0, RW_Done=0, ack=0, retry count=0.
REQ-032 Reset mid-transaction abandons the transaction; no RW_Done is produced, and the first request after release starts a fresh sequence.

Configuration
REQ-033 Macro I2C_RETRY_EN: when defined, a transaction ending with the error flag set restarts from byte 0 with the flag cleared, at most 2 retries (3 attempts in total).
REQ-034 With I2C_RETRY_EN, RW_Done pulses only on success or after the 3rd failed attempt; ack reflects the final attempt.
REQ-035 Without I2C_RETRY_EN, RW_Done pulses after a single attempt and no retry logic exists.

Verification
REQ-036 Write, addr_mode=0, id=8'h78, addr=8'h30, data=8'h5A, slave ACKs -> Go×3; Cmd/Tx = {02|01,78}, {01,30}, {09,5A}; RW_Done×1; ack=0.
REQ-037 Read, addr_mode=1, id=8'h78, addr=16'h3008, model returns 8'hC3 -> Cmd/Tx = {03,78}, {01,30}, {01,08}, {03,79}, {2C,xx}; rddata=8'hC3; ack=0.
REQ-038 Write with NACK on the second byte, macro undefined -> 3 bytes still sent; RW_Done×1; ack=1.
REQ-039 Same stimulus as REQ-038 with I2C_RETRY_EN and a permanently NACKing slave -> 9 Go pulses; a single RW_Done; ack=1. A slave that NACKs only on the first attempt -> 6 Go pulses; ack=0.
REQ-040 wrreg_req and rdreg_req asserted in the same cycle -> write sequence; a rdreg_req during WAIT -> ignored, no extra Go.
REQ-041 Rst_n low during the WAIT of byte 2 -> all outputs return to reset values at once, no RW_Done; the next write completes normally.
